dkongjr_sync_decoder: RTL



---
 rtl/dkongjr_sync_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dkongjr_sync_decoder.sv
// dkongjr_sync_decoder: recovers X/Y/DE, line/frame totals and a lock flag from H/V sync+blank streams
// Ports: I_CLK/RST (async, active-high); I_PIX_CE tick enable; H_SYNCn/V_SYNCn/H_BLANKn/V_BLANKn sampled inputs;
//        O_X/O_Y/O_DE active-area position; O_LINE_START/O_FRAME_START one-clock sync-edge pulses;
//        O_HTOTAL/O_VTOTAL reference totals (valid while O_LOCKED); O_LOCKED timing stable.
// Option: define DKJR_SYNC_TOLERANCE_EN to accept line lengths within +/-1 tick of the reference.
module dkongjr_sync_decoder #(
  parameter int LOCK_FRAMES = 3,
  parameter int HMAX = 2047,
  parameter int VMAX = 1023
) (
  input  logic        I_CLK,
  input  logic        RST,
  input  logic        I_PIX_CE,
  input  logic        H_SYNCn,
  input  logic        V_SYNCn,
  input  logic        H_BLANKn,
  input  logic        V_BLANKn,
  output logic [8:0]  O_X,
  output logic [8:0]  O_Y,
  output logic        O_DE,
  output logic        O_LINE_START,
  output logic        O_FRAME_START,
  output logic [10:0] O_HTOTAL,
  output logic [9:0]  O_VTOTAL,
  output logic        O_LOCKED
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state_q, state_d;
  // sample bit order: {H_SYNCn, V_SYNCn, H_BLANKn, V_BLANKn}
  logic [3:0] s0_q, s0_d, s1_q, s1_d;
  logic [10:0] hcnt_q, hcnt_d, htot_q, htot_d, href_q, href_d;
  logic [9:0] vcnt_q, vcnt_d, vtot_q, vtot_d, vref_q, vref_d;
  logic [8:0] x_q, x_d, y_q, y_d;
  logic [3:0] match_q, match_d;
  logic de_q, de_d, ls_q, ls_d, fs_q, fs_d, bad_q, bad_d;
  logic h_edge, v_edge, hb_fall, wd, h_mis, v_mis, line_err, bad_now;
  logic [10:0] htot_now, htot_last;
  logic [9:0] vtot_now;
  assign h_edge = s1_q[3] & ~s0_q[3];
  assign v_edge = s1_q[2] & ~s0_q[2];
  assign hb_fall = s1_q[1] & ~s0_q[1];
  assign htot_now = hcnt_q + 11'd1;
  assign vtot_now = vcnt_q + 10'd1;
  // a coincident H edge means the line just finished is the freshest measurement
  assign htot_last = h_edge ? htot_now : htot_q;
`ifdef DKJR_SYNC_TOLERANCE_EN
  assign h_mis = ({1'b0, htot_now} > {1'b0, href_q} + 12'd1) || ({1'b0, href_q} > {1'b0, htot_now} + 12'd1);
`else
  assign h_mis = htot_now != href_q;
`endif
  assign v_mis = vtot_now != vref_q;
  assign line_err = h_edge & h_mis;
  assign bad_now = bad_q | line_err;
  assign wd = (hcnt_q == 11'(HMAX)) || (vcnt_q == 10'(VMAX));
  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    hcnt_d = hcnt_q;
    htot_d = htot_q;
    vcnt_d = vcnt_q;
    vtot_d = vtot_q;
    x_d = x_q;
    y_d = y_q;
    de_d = de_q;
    bad_d = bad_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    state_d = state_q;
    href_d = href_q;
    vref_d = vref_q;
    match_d = match_q;
    if (I_PIX_CE) begin
      s0_d = {H_SYNCn, V_SYNCn, H_BLANKn, V_BLANKn};
      s1_d = s0_q;
      ls_d = h_edge;
      fs_d = v_edge;
      hcnt_d = h_edge ? 11'd0 : (hcnt_q == 11'(HMAX)) ? hcnt_q : htot_now;
      htot_d = h_edge ? htot_now : htot_q;
      vcnt_d = v_edge ? 10'd0 : (h_edge && vcnt_q != 10'(VMAX)) ? vtot_now : vcnt_q;
      vtot_d = v_edge ? vtot_now : vtot_q;
      // first visible pixel (previous sample blanked) is X=0
      x_d = (s0_q[1] & s1_q[1]) ? x_q + 9'd1 : 9'd0;
      y_d = !s0_q[0] ? 9'd0 : hb_fall ? y_q + 9'd1 : y_q;
      de_d = s0_q[1] & s0_q[0];
      bad_d = v_edge ? 1'b0 : bad_now;
      if (wd) begin
        state_d = SEARCH;
        href_d = 11'd0;
        vref_d = 10'd0;
        match_d = 4'd0;
      end else if (state_q == SEARCH) begin
        state_d = v_edge ? MEASURE : SEARCH;
      end else if (state_q == MEASURE && v_edge && !bad_now && !v_mis) begin
        match_d = match_q + 4'd1;
        state_d = (match_q + 4'd1 == 4'(LOCK_FRAMES)) ? LOCKED : MEASURE;
      end else if ((state_q == MEASURE && v_edge) || (state_q == LOCKED && (line_err || (v_edge && v_mis)))) begin
        state_d = MEASURE;
        href_d = htot_last;
        vref_d = v_edge ? vtot_now : vtot_q;
        match_d = 4'd0;
      end
    end
  end
  always_ff @(posedge I_CLK or posedge RST) begin
    if (RST) begin
      state_q <= SEARCH;
      s0_q <= '1;
      s1_q <= '1;
      hcnt_q <= '0;
      htot_q <= '0;
      href_q <= '0;
      vcnt_q <= '0;
      vtot_q <= '0;
      vref_q <= '0;
      x_q <= '0;
      y_q <= '0;
      match_q <= '0;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      hcnt_q <= hcnt_d;
      htot_q <= htot_d;
      href_q <= href_d;
      vcnt_q <= vcnt_d;
      vtot_q <= vtot_d;
      vref_q <= vref_d;
      x_q <= x_d;
      y_q <= y_d;
      match_q <= match_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      bad_q <= bad_d;
    end
  end
  assign O_X = x_q;
  assign O_Y = y_q;
  assign O_DE = de_q;
  assign O_LINE_START = ls_q;
  assign O_FRAME_START = fs_q;
  assign O_HTOTAL = href_q;
  assign O_VTOTAL = vref_q;
  assign O_LOCKED = state_q == LOCKED;
endmodule
